// File: rtl/cfb_pkg.sv
// Shared constants for the CFB-128 encrypt block.
// State encoding, block width and cipher latency bounds.
package cfb_pkg;

  localparam int BLK_W   = 128;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_CIPH  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/aes128_cipher.sv
// Combinational AES-128 forward cipher with internal key expansion.
// Byte 0 of a block sits in the top 8 bits; columns are 4 bytes each.
module aes128_cipher
  import cfb_pkg::*;
(
  input  logic [BLK_W:1] state,
  input  logic [BLK_W:1] key,
  output logic [BLK_W:1] block
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k,
                                            input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    t  = t ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt,
                                           input logic [127:0] k0);
    logic [127:0] s;
    logic [127:0] k;
    logic [7:0]   rc;
    k  = k0;
    rc = 8'h01;
    s  = pt ^ k;
    for (int r = 1; r < 10; r++) begin
      s  = mix_cols(shift_rows(sub_bytes(s)));
      k  = next_key(k, rc);
      s  = s ^ k;
      rc = xtime(rc);
    end
    s = shift_rows(sub_bytes(s));
    k = next_key(k, rc);
    return s ^ k;
  endfunction

  assign block = encrypt(state, key);

endmodule

// File: rtl/cfb_enc_seq.sv
// Sequential AES-128 CFB-128 encryptor with valid/ready handshakes.
// Optional blk_cnt output enabled by defining CFB_ENC_BLKCNT_EN.
module cfb_enc_seq
  import cfb_pkg::*;
#(
  parameter int CIPHER_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [BLK_W:1] key,
  input  logic [BLK_W:1] iv,
  input  logic           load,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [BLK_W:1] plaintext,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BLK_W:1] ciphertext,
  output logic           busy
`ifdef CFB_ENC_BLKCNT_EN
  ,
  output logic [31:0]    blk_cnt
`endif
);

  if (CIPHER_LAT < LAT_MIN || CIPHER_LAT > LAT_MAX) begin : g_lat_chk
    $error("CIPHER_LAT out of range");
  end

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(CIPHER_LAT);

  state_e           state_q, state_d;
  logic [BLK_W:1]   key_q, key_d;
  logic [BLK_W:1]   fb_q, fb_d;
  logic [BLK_W:1]   pt_q, pt_d;
  logic [BLK_W:1]   ct_q, ct_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic [31:0]      blk_q, blk_d;
  logic [BLK_W:1]   core_out;

  // Cipher core input stays fixed while the FSM sits in CIPH.
  aes128_cipher u_core (
    .state (fb_q),
    .key   (key_q),
    .block (core_out)
  );

  // Next-state, datapath loads and handshake decisions.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    fb_d    = fb_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    blk_d   = blk_q;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          key_d   = key;
          fb_d    = iv;
          blk_d   = '0;
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (load) begin
          key_d = key;
          fb_d  = iv;
          blk_d = '0;
        end else if (in_valid) begin
          pt_d    = plaintext;
          cnt_d   = '0;
          state_d = S_CIPH;
        end
      end
      S_CIPH: begin
        if (cnt_q == LAT_CNT) begin
          ct_d    = core_out ^ pt_q;
          ov_d    = 1'b1;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          fb_d    = ct_q;
          ov_d    = 1'b0;
          blk_d   = blk_q + 32'd1;
          state_d = S_READY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      fb_q    <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      fb_q    <= fb_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      blk_q   <= blk_d;
    end
  end

  assign in_ready   = (state_q == S_READY);
  assign busy       = (state_q == S_CIPH) || (state_q == S_OUT);
  assign out_valid  = ov_q;
  assign ciphertext = ct_q;

`ifdef CFB_ENC_BLKCNT_EN
  assign blk_cnt = blk_q;
`else
  logic unused_blk;
  assign unused_blk = ^blk_q;
`endif

endmodule

// File: tb/tb_cfb_enc_seq.sv
// Self-checking bench for cfb_enc_seq using NIST CFB128 vectors.
// Exercises blk_cnt too when CFB_ENC_BLKCNT_EN is defined.
module tb_cfb_enc_seq;

  localparam int LAT = 3;

  logic         clk;
  logic         rst;
  logic [128:1] key, iv, plaintext, ciphertext;
  logic         load, in_valid, in_ready;
  logic         out_valid, out_ready, busy;
`ifdef CFB_ENC_BLKCNT_EN
  logic [31:0]  blk_cnt;
`endif

  cfb_enc_seq #(.CIPHER_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .iv         (iv),
    .load       (load),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
`ifdef CFB_ENC_BLKCNT_EN
    ,
    .blk_cnt    (blk_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         reload;
    logic [128:1] pt;
    logic [128:1] ct;
  } vec_t;

  localparam logic [128:1] NKEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [128:1] NIV  = 128'h000102030405060708090a0b0c0d0e0f;

  vec_t         tbl [4];
  logic [128:1] sb [$];
  int           tests = 0;
  int           fails = 0;

  task automatic check(input string nm, input logic [128:1] got,
                       input logic [128:1] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Scoreboard: pop one expected block per output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %h expected none", ciphertext);
      end else begin
        check("ct", ciphertext, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [128:1] k, input logic [128:1] v);
    load = 1'b1;
    key  = k;
    iv   = v;
    tick();
    load = 1'b0;
  endtask

  task automatic send(input logic [128:1] p, input logic [128:1] e);
    int n;
    n         = 0;
    in_valid  = 1'b1;
    plaintext = p;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
      in_valid = 1'b0;
    end else begin
      sb.push_back(e);
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [128:1] ks1, p;
    logic         ok;

    tbl[0] = '{1'b1, 128'h6bc1bee22e409f96e93d7e117393172a,
                     128'h3b3fd92eb72dad20333449f8e83cfb4a};
    tbl[1] = '{1'b0, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                     128'hc8a64537a0b3a93fcde3cdad9f1ce58b};
    tbl[2] = '{1'b0, 128'h30c81c46a35ce411e5fbc1191a0a52ef,
                     128'h26751f67a3cbb140b1808cf187a4f4df};
    tbl[3] = '{1'b0, 128'hf69f2445df4f9b17ad2b417be66c3710,
                     128'hc04b05357c5d1c0eeac4c66f9ff7f2e6};
    ks1 = tbl[0].pt ^ tbl[0].ct;

    rst       = 1'b1;
    load      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    key       = '0;
    iv        = '0;
    plaintext = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_ct", ciphertext, 128'd0);
`ifdef CFB_ENC_BLKCNT_EN
    check("rst_blk_cnt", 128'(blk_cnt), 128'd0);
`endif
    tick();
    check("idle_in_ready", 128'(in_ready), 128'd0);

    // NIST chained vectors, back to back.
    for (int i = 0; i < 4; i++) begin
      if (tbl[i].reload) begin
        do_load(NKEY, NIV);
        check("load_ready", 128'(in_ready), 128'd1);
      end
      send(tbl[i].pt, tbl[i].ct);
    end
    drain();
`ifdef CFB_ENC_BLKCNT_EN
    check("blk_cnt_4", 128'(blk_cnt), 128'd4);
`endif

    // Latency and backpressure.
    out_ready = 1'b0;
    do_load(NKEY, NIV);
`ifdef CFB_ENC_BLKCNT_EN
    check("blk_cnt_clr", 128'(blk_cnt), 128'd0);
`endif
    send(tbl[0].pt, tbl[0].ct);
    repeat (LAT) tick();
    check("lat_early", 128'(out_valid), 128'd0);
    tick();
    check("lat_valid", 128'(out_valid), 128'd1);
    check("lat_ct", ciphertext, tbl[0].ct);
    ok        = 1'b1;
    in_valid  = 1'b1;
    plaintext = tbl[1].pt;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ciphertext !== tbl[0].ct || out_valid !== 1'b1 ||
          in_ready !== 1'b0 || busy !== 1'b1)
        ok = 1'b0;
    end
    check("bp_hold", 128'(ok), 128'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("bp_drain", 128'(sb.size()), 128'd0);
    check("bp_no_second", 128'(busy), 128'd0);
    check("bp_ov_low", 128'(out_valid), 128'd0);
`ifdef CFB_ENC_BLKCNT_EN
    check("bp_blk_cnt", 128'(blk_cnt), 128'd1);
`endif

    // load in CIPH/OUT is ignored: chaining continues to vector 3.
    out_ready = 1'b0;
    send(tbl[1].pt, tbl[1].ct);
    do_load(~NKEY, ~NIV);
    repeat (LAT + 2) tick();
    do_load(~NKEY, ~NIV);
    out_ready = 1'b1;
    drain();
    send(tbl[2].pt, tbl[2].ct);
    drain();

    // Simultaneous load and in_valid in READY: load wins.
    do_load(NKEY, 128'h0);
    load      = 1'b1;
    key       = NKEY;
    iv        = NIV;
    in_valid  = 1'b1;
    plaintext = 128'hdeadbeef;
    tick();
    load     = 1'b0;
    in_valid = 1'b0;
    check("lw_busy", 128'(busy), 128'd0);
    check("lw_ready", 128'(in_ready), 128'd1);
    send(tbl[0].pt, tbl[0].ct);
    drain();

    // Reset in CIPH aborts the message.
    out_ready = 1'b0;
    do_load(NKEY, NIV);
    send(tbl[1].pt, 128'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    repeat (LAT + 3) tick();
    check("rc_ov", 128'(out_valid), 128'd0);
    check("rc_ready", 128'(in_ready), 128'd0);
    check("rc_busy", 128'(busy), 128'd0);
    check("rc_ct", ciphertext, 128'd0);
    out_ready = 1'b1;
    do_load(NKEY, NIV);
    send(tbl[0].pt, tbl[0].ct);
    drain();

    // Random plaintext against the known first keystream block.
    for (int i = 0; i < 24; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      do_load(NKEY, NIV);
      send(p, p ^ ks1);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
